// File: rtl/vga_fb_arbiter.sv
// vga_fb_arbiter: shares one single-port, two-cycle-latency framebuffer RAM
// between the fixed-schedule video pixel fetch (absolute priority) and a
// req/ack CPU load/store port. The fetched color leaves together with the
// pixel/line counters delayed by the same three clocks, so the downstream
// output stage sees aligned color and position.
module vga_fb_arbiter #(
  parameter int unsigned FB_W     = 160,
  parameter int unsigned FB_H     = 120,
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned FB_SIZE  = FB_W * FB_H
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic [9:0]  pixel_counter,
  input  logic [8:0]  line_counter,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [14:0] cpu_addr,
  input  logic [7:0]  cpu_wdata,
  output logic        cpu_ack,
  output logic [7:0]  cpu_rdata,
  output logic [14:0] ram_addr,
  output logic        ram_we,
  output logic [7:0]  ram_wdata,
  input  logic [7:0]  ram_rdata,
  output logic [7:0]  color_out,
  output logic [9:0]  pixel_out,
  output logic [8:0]  line_out
);

  localparam logic [9:0]  H_END     = 10'(H_ACTIVE);
  localparam logic [8:0]  V_END     = 9'(V_ACTIVE);
  localparam logic [6:0]  FB_ROWS   = 7'(FB_H);
  localparam logic [14:0] FB_STRIDE = 15'(FB_W);
  localparam logic [14:0] FB_END    = 15'(FB_SIZE);

  typedef enum logic [1:0] {
    IDLE,
    ISSUED,
    DATA,
    ACK
  } state_t;

  state_t      state;
  logic        in_active;
  logic        slot;
  logic [14:0] line_blk;
  logic [14:0] video_addr;
  logic        cpu_in_range;
  logic        in_range_q;
  logic        we_q;

  // Tagged delay pipeline: counters plus "visible" and "fetch issued" tags.
  logic [9:0]  d0_pixel;
  logic [8:0]  d0_line;
  logic        d0_act;
  logic        d0_cap;
  logic [9:0]  d1_pixel;
  logic [8:0]  d1_line;
  logic        d1_act;
  logic        d1_cap;

  // Decode the video fetch slot, its framebuffer address and the CPU range check.
  always_comb begin
    in_active    = (pixel_counter < H_END) && (line_counter < V_END);
    // The row bound keeps fetches inside the framebuffer even if the
    // display and framebuffer geometry parameters were set inconsistently.
    slot         = enable && in_active && (pixel_counter[1:0] == 2'b00)
                   && (line_counter[8:2] < FB_ROWS);
    line_blk     = {8'b0, line_counter[8:2]};
    // Constant stride product; for 160 this reduces to (l<<7)+(l<<5).
    video_addr   = (line_blk * FB_STRIDE) + {7'b0, pixel_counter[9:2]};
    cpu_in_range = (cpu_addr < FB_END);
  end

  // Delay the counters three clocks and capture the fetched color on the
  // cycle its read data arrives; invisible or disabled positions show black.
  always_ff @(posedge clk) begin
    if (reset) begin
      d0_pixel  <= '0;
      d0_line   <= '0;
      d0_act    <= 1'b0;
      d0_cap    <= 1'b0;
      d1_pixel  <= '0;
      d1_line   <= '0;
      d1_act    <= 1'b0;
      d1_cap    <= 1'b0;
      pixel_out <= '0;
      line_out  <= '0;
      color_out <= '0;
    end else begin
      d0_pixel  <= pixel_counter;
      d0_line   <= line_counter;
      d0_act    <= enable && in_active;
      d0_cap    <= slot;
      d1_pixel  <= d0_pixel;
      d1_line   <= d0_line;
      d1_act    <= d0_act;
      d1_cap    <= d0_cap;
      pixel_out <= d1_pixel;
      line_out  <= d1_line;
      if (!enable || !d1_act) begin
        color_out <= '0;
      end else if (d1_cap) begin
        color_out <= ram_rdata;
      end
    end
  end

  // RAM port ownership and the CPU access FSM; a grant is only possible in a
  // non-slot cycle, so at most one requester loads ram_addr per clock.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      ram_addr   <= '0;
      ram_we     <= 1'b0;
      ram_wdata  <= '0;
      cpu_ack    <= 1'b0;
      cpu_rdata  <= '0;
      in_range_q <= 1'b0;
      we_q       <= 1'b0;
    end else begin
      ram_we <= 1'b0;
      if (slot) begin
        ram_addr <= video_addr;
      end
      case (state)
        IDLE: begin
          if (cpu_req && !slot) begin
            ram_addr   <= cpu_addr;
            ram_wdata  <= cpu_wdata;
            ram_we     <= cpu_we && cpu_in_range;
            in_range_q <= cpu_in_range;
            we_q       <= cpu_we;
            state      <= ISSUED;
          end
        end
        ISSUED: begin
          state <= DATA;
        end
        DATA: begin
          if (!we_q) begin
            cpu_rdata <= in_range_q ? ram_rdata : '0;
          end
          cpu_ack <= 1'b1;
          state   <= ACK;
        end
        ACK: begin
          cpu_ack <= 1'b0;
          state   <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_vga_fb_arbiter.sv
// Scoreboard bench for vga_fb_arbiter: the driver pushes expected video,
// CPU-ack, RAM-write, RAM-address and reset-state observations with the
// cycle they are due; a separate monitor pops and compares them.
module tb_vga_fb_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        enable;
  logic [9:0]  pixel_counter;
  logic [8:0]  line_counter;
  logic        cpu_req;
  logic        cpu_we;
  logic [14:0] cpu_addr;
  logic [7:0]  cpu_wdata;
  logic        cpu_ack;
  logic [7:0]  cpu_rdata;
  logic [14:0] ram_addr;
  logic        ram_we;
  logic [7:0]  ram_wdata;
  logic [7:0]  ram_rdata;
  logic [7:0]  color_out;
  logic [9:0]  pixel_out;
  logic [8:0]  line_out;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;
  bit done  = 1'b0;

  typedef struct { int due; int p; int l; logic [7:0] c; } vid_t;
  typedef struct { int due; logic [7:0] rdata; } cpu_t;
  typedef struct { int due; int addr; int data; } wr_t;
  typedef struct { int due; int addr; } adr_t;

  vid_t vq[$];
  cpu_t cq[$];
  wr_t  wq[$];
  adr_t aq[$];
  int   zq[$];

  logic [7:0] ref_mem [int];

  vga_fb_arbiter dut (
    .clk           (clk),
    .reset         (reset),
    .enable        (enable),
    .pixel_counter (pixel_counter),
    .line_counter  (line_counter),
    .cpu_req       (cpu_req),
    .cpu_we        (cpu_we),
    .cpu_addr      (cpu_addr),
    .cpu_wdata     (cpu_wdata),
    .cpu_ack       (cpu_ack),
    .cpu_rdata     (cpu_rdata),
    .ram_addr      (ram_addr),
    .ram_we        (ram_we),
    .ram_wdata     (ram_wdata),
    .ram_rdata     (ram_rdata),
    .color_out     (color_out),
    .pixel_out     (pixel_out),
    .line_out      (line_out)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Power-on framebuffer contents.
  function automatic logic [7:0] init_val(input int a);
    logic [31:0] v;
    v = a;
    return v[7:0] ^ 8'h3C;
  endfunction

  // Synchronous RAM, read-first: address registered at one edge, data out after the next.
  bit [7:0] mem [32768];
  bit       written [32768];
  always @(posedge clk) begin
    if (ram_we) begin
      mem[ram_addr]     <= ram_wdata;
      written[ram_addr] <= 1'b1;
    end
    ram_rdata <= written[ram_addr] ? mem[ram_addr] : init_val(int'(ram_addr));
  end

  // Color a position should show: its 4x4 block's framebuffer byte, or black.
  function automatic logic [7:0] exp_color(input int p, input int l, input logic en);
    int a;
    if (!en || p >= 640 || l >= 480) return 8'h00;
    a = (l / 4) * 160 + p / 4;
    return ref_mem.exists(a) ? ref_mem[a] : init_val(a);
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick();
    logic a;
    @(negedge clk);
    a = cpu_ack;
    @(posedge clk);
    #1;
    if (a) cpu_req = 1'b0;
  endtask

  task automatic step(input int p, input int l);
    vid_t v;
    pixel_counter = p[9:0];
    line_counter  = l[8:0];
    if (!reset) begin
      v.due = cyc + 3;
      v.p   = p;
      v.l   = l;
      v.c   = exp_color(p, l, enable);
      vq.push_back(v);
    end
    tick();
  endtask

  task automatic blank(input int n);
    for (int i = 0; i < n; i++) step(700, 500);
  endtask

  task automatic expect_addr(input int due, input int addr);
    adr_t a;
    a.due  = due;
    a.addr = addr;
    aq.push_back(a);
  endtask

  task automatic cpu_issue(input logic we, input int addr, input logic [7:0] wdata,
                           input int lat, input logic [7:0] exp_rdata, input logic exp_we);
    cpu_t c;
    wr_t  w;
    cpu_req   = 1'b1;
    cpu_we    = we;
    cpu_addr  = addr[14:0];
    cpu_wdata = wdata;
    c.due   = cyc + lat;
    c.rdata = exp_rdata;
    cq.push_back(c);
    if (exp_we) begin
      w.due  = cyc + lat - 2;
      w.addr = addr;
      w.data = int'(wdata);
      wq.push_back(w);
      ref_mem[addr] = wdata;
    end
  endtask

  // Driver
  initial begin : driver
    int lines [4];
    lines = '{3, 4, 7, 8};
    reset = 1'b1; enable = 1'b1;
    pixel_counter = 10'd700; line_counter = 9'd500;
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 15'd162; cpu_wdata = 8'hFF;
    @(posedge clk);
    #1;
    // Reset held with a request pending: everything must read zero.
    for (int i = 0; i < 3; i++) begin
      zq.push_back(cyc + 1);
      step(700, 500);
    end
    reset = 1'b0;
    cpu_req = 1'b0;
    blank(5);

    // Blanking accesses: granted immediately, ack three cycles later.
    cpu_issue(1'b0, 0, 8'h00, 3, 8'h3C, 1'b0);   blank(6);
    cpu_issue(1'b1, 162, 8'hE0, 3, 8'h3C, 1'b1); blank(6);

    // Video around the written block (162 = row 1, column 2).
    foreach (lines[k]) for (int p = 0; p < 20; p++) step(p, lines[k]);
    blank(3);

    // Request lands on a video slot: video address 165 first, then the CPU's 162.
    expect_addr(cyc + 1, 165);
    expect_addr(cyc + 2, 162);
    cpu_issue(1'b0, 162, 8'h00, 4, 8'hE0, 1'b0);
    for (int p = 20; p < 32; p++) step(p, 4);
    blank(4);

    // Read-back, out-of-range read/write, last in-range address.
    cpu_issue(1'b0, 162, 8'h00, 3, 8'hE0, 1'b0);   blank(6);
    cpu_issue(1'b0, 19200, 8'h00, 3, 8'h00, 1'b0); blank(6);
    cpu_issue(1'b1, 19200, 8'h55, 3, 8'h00, 1'b0); blank(6);
    cpu_issue(1'b0, 19199, 8'h00, 3, 8'hC3, 1'b0); blank(6);

    // A full disabled line: no fetch loads, black output, CPU still served.
    enable = 1'b0;
    blank(4);
    for (int p = 0; p < 640; p++) begin
      if (p == 100) expect_addr(cyc, 19199);
      if (p == 320) cpu_issue(1'b0, 162, 8'h00, 3, 8'hE0, 1'b0);
      if (p == 600) expect_addr(cyc, 162);
      step(p, 8);
    end
    blank(4);
    enable = 1'b1;
    blank(4);
    for (int p = 0; p < 16; p++) step(p, 8);
    blank(4);

    // Reset while the FSM is in DATA: no ack, then a reissue completes.
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 15'd200;
    step(700, 500);
    step(700, 500);
    reset = 1'b1;
    cpu_req = 1'b0;
    while (vq.size() > 0 && vq[vq.size() - 1].due > cyc) void'(vq.pop_back());
    zq.push_back(cyc + 1);
    step(700, 500);
    reset = 1'b0;
    blank(5);
    cpu_issue(1'b0, 200, 8'h00, 3, 8'hF4, 1'b0);
    blank(6);

    for (int i = 0; i < 4; i++) tick();
    done = 1'b1;
  end

  // Monitor
  initial begin : monitor
    vid_t v;
    cpu_t c;
    wr_t  w;
    adr_t a;
    bit   exp_ack;
    bit   exp_we;
    while (!done) begin
      @(negedge clk);
      if (zq.size() > 0 && zq[0] == cyc) begin
        void'(zq.pop_front());
        chk("reset_ram_addr",  int'(ram_addr),  0);
        chk("reset_ram_we",    int'(ram_we),    0);
        chk("reset_ram_wdata", int'(ram_wdata), 0);
        chk("reset_cpu_ack",   int'(cpu_ack),   0);
        chk("reset_cpu_rdata", int'(cpu_rdata), 0);
        chk("reset_color",     int'(color_out), 0);
        chk("reset_pixel_out", int'(pixel_out), 0);
        chk("reset_line_out",  int'(line_out),  0);
      end
      if (vq.size() > 0 && vq[0].due == cyc) begin
        v = vq.pop_front();
        chk("color_out", int'(color_out), int'(v.c));
        chk("pixel_out", int'(pixel_out), v.p);
        chk("line_out",  int'(line_out),  v.l);
      end
      exp_ack = (cq.size() > 0 && cq[0].due == cyc);
      chk("cpu_ack", int'(cpu_ack), int'(exp_ack));
      if (exp_ack) begin
        c = cq.pop_front();
        if (cpu_ack) chk("cpu_rdata", int'(cpu_rdata), int'(c.rdata));
      end
      exp_we = (wq.size() > 0 && wq[0].due == cyc);
      chk("ram_we", int'(ram_we), int'(exp_we));
      if (exp_we) begin
        w = wq.pop_front();
        if (ram_we) begin
          chk("ram_we_addr",  int'(ram_addr),  w.addr);
          chk("ram_we_wdata", int'(ram_wdata), w.data);
        end
      end
      if (aq.size() > 0 && aq[0].due == cyc) begin
        a = aq.pop_front();
        chk("ram_addr", int'(ram_addr), a.addr);
      end
      if (cyc > 5000) begin
        tests++;
        fails++;
        $display("FAIL watchdog: got cycle %0d, expected finish before 5000", cyc);
        break;
      end
    end
    chk("queues_drained", vq.size() + cq.size() + wq.size() + aq.size() + zq.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
